// File: rtl/udma_smi_pkg.sv
// Shared definitions for the uDMA SMI (MDIO) master.
// Provides config-bus word addresses, MDIO frame constants, the command
// record stored in the command FIFO and the frame engine state type.
package udma_smi_pkg;

  // Config-bus word addresses
  localparam logic [4:0] REG_CMD     = 5'h00;
  localparam logic [4:0] REG_STATUS  = 5'h01;
  localparam logic [4:0] REG_RX_DATA = 5'h02;
  localparam logic [4:0] REG_CLKDIV  = 5'h03;
  localparam logic [4:0] REG_CFG     = 5'h04;

  // Start-of-frame patterns
  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  // Opcodes as they appear on the wire
  localparam logic [1:0] OP22_WRITE = 2'b01;
  localparam logic [1:0] OP22_READ  = 2'b10;
  localparam logic [1:0] OP45_ADDR  = 2'b00;
  localparam logic [1:0] OP45_WRITE = 2'b01;
  localparam logic [1:0] OP45_READ  = 2'b11;
  localparam logic [1:0] OP45_PRIA  = 2'b10;

  // Turnaround driven by the master on write/address frames
  localparam logic [1:0] TA_DRIVE = 2'b10;

  // Layout matches CMD register bits [28:0]
  typedef struct packed {
    logic        c45;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] data;
  } smi_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRE   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } smi_state_e;

  // Post-read-increment is a read as far as the bus is concerned
  function automatic logic is_read_op(input smi_cmd_t c);
    return c.c45 ? ((c.op == OP45_READ) || (c.op == OP45_PRIA))
                 : (c.op == OP22_READ);
  endfunction

endpackage

// File: rtl/udma_smi_cmd_fifo.sv
// Synchronous command FIFO for the SMI master.
// Ports: clk_i/rstn_i clock and async active-low reset; push_i/wdata_i write
// side; pop_i/rdata_o read side (rdata_o shows the head entry); full_o,
// empty_o, level_o occupancy. A push while full is accepted only when a pop
// happens in the same cycle.
module udma_smi_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 29
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty can be told apart
  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level_o = wptr - rptr;
  assign rdata_o = mem[rptr[AW-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/udma_smi_master.sv
// MDIO/SMI master behind the uDMA config bus (clause 22 and clause 45).
// Ports: clk_i/rstn_i clock and async active-low reset; cfg_* config bus
// (word address, write data, combinational read data, always ready);
// mdc_o/mdio_o/mdio_oe_o/mdio_i pad side; irq_o registered level interrupt.
// Holds the register file, MDC divider and frame engine; commands are queued
// in udma_smi_cmd_fifo.
module udma_smi_master
  import udma_smi_pkg::*;
#(
  parameter int unsigned          CMD_DEPTH  = 4,
  parameter int unsigned          CLKDIV_W   = 8,
  parameter logic [CLKDIV_W-1:0]  CLKDIV_RST = 8'd24,
  parameter int unsigned          PRE_LEN    = 32
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] cfg_data_i,
  input  logic [4:0]  cfg_addr_i,
  input  logic        cfg_valid_i,
  input  logic        cfg_rwn_i,
  output logic [31:0] cfg_data_o,
  output logic        cfg_ready_o,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_oe_o,
  input  logic        mdio_i,
  output logic        irq_o
);

  localparam int unsigned LVL_W = $clog2(CMD_DEPTH) + 1;
  localparam int unsigned PRE_W = $clog2(PRE_LEN) + 1;
  localparam int unsigned CMD_W = $bits(smi_cmd_t);

  logic                cfg_wr, cfg_rd, push, pop, full, empty, busy, rx_rd;
  logic [LVL_W-1:0]    level;
  logic [CMD_W-1:0]    fifo_rdata;
  smi_cmd_t            head;
  logic [31:0]         new_frame;
  logic                unused_cfg_bits;

  logic [CLKDIV_W-1:0] clkdiv_q, div_q, div_cnt;
  logic                cfg_pre_sup, cfg_irq_nd, cfg_irq_idle;
  logic                ovf_q, nd_q, irq_q;
  logic [15:0]         rx_data_q, rx_shift_q;
  smi_state_e          state_q;
  logic [31:0]         frame_q;
  logic [4:0]          bit_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic                rd_op_q, mdc_q, mdio_q, mdio_oe_q;

  assign cfg_wr          = cfg_valid_i & ~cfg_rwn_i;
  assign cfg_rd          = cfg_valid_i & cfg_rwn_i;
  assign push            = cfg_wr && (cfg_addr_i == REG_CMD);
  assign rx_rd           = cfg_rd && (cfg_addr_i == REG_RX_DATA);
  assign pop             = (state_q == S_IDLE) && !empty;
  assign busy            = (state_q != S_IDLE) || !empty;
  assign unused_cfg_bits = ^cfg_data_i[31:29];

  udma_smi_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) i_cmd_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .wdata_i (cfg_data_i[CMD_W-1:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign head      = smi_cmd_t'(fifo_rdata);
  assign new_frame = {(head.c45 ? ST_C45 : ST_C22), head.op, head.phyad,
                      head.regad, TA_DRIVE, head.data};

  // Register file
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      clkdiv_q     <= CLKDIV_RST;
      cfg_pre_sup  <= 1'b0;
      cfg_irq_nd   <= 1'b0;
      cfg_irq_idle <= 1'b0;
      ovf_q        <= 1'b0;
      nd_q         <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      if (cfg_wr && (cfg_addr_i == REG_CLKDIV)) clkdiv_q <= cfg_data_i[CLKDIV_W-1:0];
      if (cfg_wr && (cfg_addr_i == REG_CFG))
        {cfg_irq_idle, cfg_irq_nd, cfg_pre_sup} <= cfg_data_i[2:0];
      if (push && full && !pop)
        ovf_q <= 1'b1;
      else if (cfg_wr && (cfg_addr_i == REG_CFG) && cfg_data_i[3])
        ovf_q <= 1'b0;
      // A result landing in the same cycle as an RX_DATA read keeps ND set
      nd_q  <= ((state_q == S_DONE) && rd_op_q) | (nd_q & ~rx_rd);
      irq_q <= (cfg_irq_nd & nd_q) | (cfg_irq_idle & ~busy);
    end
  end

  always_comb begin
    cfg_data_o = '0;
    case (cfg_addr_i)
      REG_STATUS: begin
        cfg_data_o[0]           = busy;
        cfg_data_o[1]           = empty;
        cfg_data_o[2]           = full;
        cfg_data_o[3]           = ovf_q;
        cfg_data_o[4]           = nd_q;
        cfg_data_o[8 +: LVL_W]  = level;
      end
      REG_RX_DATA: cfg_data_o[15:0]         = rx_data_q;
      REG_CLKDIV:  cfg_data_o[CLKDIV_W-1:0] = clkdiv_q;
      REG_CFG:     cfg_data_o[2:0]          = {cfg_irq_idle, cfg_irq_nd, cfg_pre_sup};
      default:     cfg_data_o               = '0;
    endcase
  end

  // Frame engine. frame_q[31] is always the bit on the wire during SHIFT;
  // the divider reload value is latched per frame so CLKDIV writes only
  // affect later frames.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      mdc_q      <= 1'b0;
      mdio_q     <= 1'b1;
      mdio_oe_q  <= 1'b0;
      div_q      <= '0;
      div_cnt    <= '0;
      frame_q    <= '0;
      bit_cnt    <= '0;
      pre_cnt    <= '0;
      rd_op_q    <= 1'b0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            state_q   <= cfg_pre_sup ? S_SHIFT : S_PRE;
            frame_q   <= new_frame;
            rd_op_q   <= is_read_op(head);
            div_q     <= clkdiv_q;
            div_cnt   <= '0;
            mdc_q     <= 1'b0;
            bit_cnt   <= '0;
            pre_cnt   <= '0;
            mdio_oe_q <= 1'b1;
            mdio_q    <= cfg_pre_sup ? new_frame[31] : 1'b1;
          end
        end
        S_PRE, S_SHIFT: begin
          if (div_cnt == div_q) begin
            div_cnt <= '0;
            mdc_q   <= ~mdc_q;
            if (!mdc_q) begin
              // Rising MDC: sample read data bits
              if ((state_q == S_SHIFT) && rd_op_q && (bit_cnt >= 5'd16))
                rx_shift_q <= {rx_shift_q[14:0], mdio_i};
            end else if (state_q == S_PRE) begin
              if (pre_cnt == PRE_W'(PRE_LEN - 1)) begin
                state_q <= S_SHIFT;
                mdio_q  <= frame_q[31];
              end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
              end
            end else if (bit_cnt == 5'd31) begin
              state_q <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              frame_q <= {frame_q[30:0], 1'b0};
              // Next bit index >= 14 on a read: PHY owns the line from TA on
              if (rd_op_q && (bit_cnt >= 5'd13)) begin
                mdio_oe_q <= 1'b0;
                mdio_q    <= 1'b1;
              end else begin
                mdio_q <= frame_q[30];
              end
            end
          end else begin
            div_cnt <= div_cnt + CLKDIV_W'(1);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          mdio_oe_q <= 1'b0;
          mdio_q    <= 1'b1;
          mdc_q     <= 1'b0;
          if (rd_op_q) rx_data_q <= rx_shift_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready_o = 1'b1;
  assign mdc_o       = mdc_q;
  assign mdio_o      = mdio_q;
  assign mdio_oe_o   = mdio_oe_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_udma_smi_master.sv
module tb_udma_smi_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] cfg_data_i;
  logic [4:0]  cfg_addr_i;
  logic        cfg_valid_i;
  logic        cfg_rwn_i;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_o;
  logic        mdc_o, mdio_o, mdio_oe_o, irq_o;
  logic        mdio_i = 1'b1;

  udma_smi_master #(
    .CMD_DEPTH  (4),
    .CLKDIV_W   (8),
    .CLKDIV_RST (8'd24),
    .PRE_LEN    (32)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .cfg_data_i  (cfg_data_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_valid_i (cfg_valid_i),
    .cfg_rwn_i   (cfg_rwn_i),
    .cfg_data_o  (cfg_data_o),
    .cfg_ready_o (cfg_ready_o),
    .mdc_o       (mdc_o),
    .mdio_o      (mdio_o),
    .mdio_oe_o   (mdio_oe_o),
    .mdio_i      (mdio_i),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard of expected MDIO frames ----------------
  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    int unsigned len;
    logic        is_rd;
    logic [15:0] rd;
  } exp_frame_t;

  exp_frame_t  fq[$];
  logic [15:0] rxq[$];
  int unsigned cur_len = 0;
  int unsigned frames_seen = 0;
  logic [63:0] cap, cap_oe;
  time         first_t = 0, last_end_t = 0, gap_t = 0, period_t = 0;

  function automatic exp_frame_t make_frame(input bit c45, input logic [1:0] op,
      input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] data,
      input bit pre, input logic [15:0] rd);
    exp_frame_t f;
    logic [31:0] fr;
    logic [31:0] oe;
    f.is_rd = c45 ? op[1] : (op == 2'b10);
    fr      = {1'b0, ~c45, op, phy, rg, 2'b10, data};
    oe      = f.is_rd ? 32'hFFFC_0000 : 32'hFFFF_FFFF;
    f.len   = pre ? 64 : 32;
    f.bits  = pre ? {32'hFFFF_FFFF, fr} : {32'h0, fr};
    f.oe    = pre ? {32'hFFFF_FFFF, oe} : {32'h0, oe};
    f.rd    = rd;
    return f;
  endfunction

  // Bus monitor: collects one bit per rising MDC and checks whole frames
  always @(posedge mdc_o or negedge rstn) begin
    if (!rstn) begin
      cur_len = 0;
      fq.delete();
    end else if (fq.size() == 0) begin
      check("unexpected_mdc_activity", 64'(cur_len), 64'hFFFF);
    end else begin
      if (cur_len == 0) begin
        first_t = $time;
        gap_t   = first_t - last_end_t;
        cap     = '0;
        cap_oe  = '0;
      end
      if (cur_len == 1) period_t = $time - first_t;
      cap    = {cap[62:0], mdio_o};
      cap_oe = {cap_oe[62:0], mdio_oe_o};
      cur_len++;
      if (cur_len == fq[0].len) begin
        logic [63:0] m;
        m = (fq[0].len == 64) ? '1 : 64'hFFFF_FFFF;
        check("frame_oe", cap_oe & m, fq[0].oe & m);
        check("frame_bits", cap & fq[0].oe & m, fq[0].bits & fq[0].oe & m);
        void'(fq.pop_front());
        cur_len    = 0;
        last_end_t = $time;
        frames_seen++;
      end
    end
  end

  // PHY model: drives read data after falling MDC, MSB first
  always @(negedge mdc_o) begin
    int j;
    mdio_i = 1'b1;
    if (fq.size() != 0 && fq[0].is_rd) begin
      j = int'(cur_len) - ((fq[0].len == 64) ? 32 : 0);
      if (j >= 16 && j <= 31) mdio_i = fq[0].rd[4'(31 - j)];
    end
  end

  // ---------------- config bus tasks (entered just after posedge) -----
  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_addr_i = a; cfg_data_i = d; cfg_rwn_i = 1'b0; cfg_valid_i = 1'b1;
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
    cfg_addr_i = a; cfg_rwn_i = 1'b1; cfg_valid_i = 1'b1;
    @(negedge clk);
    d = cfg_data_o;
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic push_cmd(input bit c45, input logic [1:0] op, input logic [4:0] phy,
      input logic [4:0] rg, input logic [15:0] data, input bit pre, input logic [15:0] rd);
    exp_frame_t f;
    f = make_frame(c45, op, phy, rg, data, pre, rd);
    fq.push_back(f);
    if (f.is_rd) rxq.push_back(rd);
    cfg_write(5'h00, {3'b0, c45, op, phy, rg, data});
  endtask

  task automatic wait_frames(input int unsigned n, input int unsigned budget, input string name);
    int unsigned k = 0;
    while (frames_seen < n && k < budget) begin @(posedge clk); k++; end
    #1;
    check(name, 64'(frames_seen >= n), 64'd1);
  endtask

  task automatic wait_idle(input int unsigned budget, input string name);
    logic [31:0] d;
    int unsigned k = 0;
    cfg_read(5'h01, d);
    while (d[0] && k < budget) begin cfg_read(5'h01, d); k++; end
    check(name, 64'(d[0]), 64'd0);
  endtask

  // ---------------- register table ----------------
  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  function automatic vec_t v(input bit wr, input logic [4:0] a, input logic [31:0] w,
      input logic [31:0] e, input string n);
    vec_t r;
    r.wr = wr; r.addr = a; r.wdata = w; r.exp = e; r.name = n;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[15];
    logic [31:0] d;
    exp_frame_t  f;
    int unsigned base;

    vt[0]  = v(0, 5'h01, 32'h0,        32'h2,  "status_rst");
    vt[1]  = v(0, 5'h03, 32'h0,        32'd24, "clkdiv_rst");
    vt[2]  = v(0, 5'h02, 32'h0,        32'h0,  "rxdata_rst");
    vt[3]  = v(0, 5'h04, 32'h0,        32'h0,  "cfg_rst");
    vt[4]  = v(0, 5'h00, 32'h0,        32'h0,  "cmd_wo");
    vt[5]  = v(0, 5'h05, 32'h0,        32'h0,  "unmapped5");
    vt[6]  = v(0, 5'h1F, 32'h0,        32'h0,  "unmapped31");
    vt[7]  = v(1, 5'h03, 32'h5A,       32'h0,  "");
    vt[8]  = v(0, 5'h03, 32'h0,        32'h5A, "clkdiv_rw");
    vt[9]  = v(1, 5'h04, 32'h9,        32'h0,  "");
    vt[10] = v(0, 5'h04, 32'h0,        32'h1,  "cfg_bit3_selfclr");
    vt[11] = v(1, 5'h04, 32'h0,        32'h0,  "");
    vt[12] = v(0, 5'h04, 32'h0,        32'h0,  "cfg_clear");
    vt[13] = v(1, 5'h03, 32'hFFFF_FF01, 32'h0, "");
    vt[14] = v(0, 5'h03, 32'h0,        32'h1,  "clkdiv_width");

    cfg_valid_i = 1'b0; cfg_rwn_i = 1'b1; cfg_addr_i = '0; cfg_data_i = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    check("rst_mdc", 64'(mdc_o), 64'd0);
    check("rst_mdio", 64'(mdio_o), 64'd1);
    check("rst_oe", 64'(mdio_oe_o), 64'd0);
    check("rst_irq", 64'(irq_o), 64'd0);
    check("cfg_ready", 64'(cfg_ready_o), 64'd1);

    for (int unsigned i = 0; i < 15; i++) begin
      if (vt[i].wr) cfg_write(vt[i].addr, vt[i].wdata);
      else begin
        cfg_read(vt[i].addr, d);
        check(vt[i].name, 64'(d), 64'(vt[i].exp));
      end
    end

    // C22 write with preamble, CLKDIV=1 -> MDC period 4 clk
    f.len   = 64;
    f.bits  = {32'hFFFF_FFFF, 32'b0101_00011_00100_10_1011111011101111};
    f.oe    = '1;
    f.is_rd = 1'b0;
    f.rd    = '0;
    fq.push_back(f);
    cfg_write(5'h00, {3'b0, 1'b0, 2'b01, 5'd3, 5'd4, 16'hBEEF});
    wait_frames(1, 400, "c22_write_frame");
    check("mdc_period", 64'(period_t), 64'd40);
    wait_idle(20, "c22_write_idle");
    cfg_read(5'h01, d);
    check("c22_write_status", 64'(d), 64'h2);

    // C22 read, irq on new data
    cfg_write(5'h04, 32'h2);
    push_cmd(1'b0, 2'b10, 5'd1, 5'd2, 16'h0, 1'b1, 16'h1234);
    wait_frames(2, 400, "c22_read_frame");
    wait_idle(20, "c22_read_idle");
    cfg_read(5'h01, d);
    check("c22_read_status_nd", 64'(d), 64'h12);
    check("c22_read_irq", 64'(irq_o), 64'd1);
    cfg_read(5'h02, d);
    check("c22_rxdata", 64'(d), 64'(rxq.pop_front()));
    check("irq_lag", 64'(irq_o), 64'd1);
    @(posedge clk); #1;
    check("irq_drop", 64'(irq_o), 64'd0);
    cfg_read(5'h01, d);
    check("nd_cleared", 64'(d), 64'h2);

    // Idle interrupt
    cfg_write(5'h04, 32'h4);
    @(posedge clk); #1;
    check("irq_idle_on", 64'(irq_o), 64'd1);
    cfg_write(5'h04, 32'h0);
    @(posedge clk); #1;
    check("irq_idle_off", 64'(irq_o), 64'd0);

    // C45 address + read, preamble suppressed, back-to-back
    cfg_write(5'h04, 32'h1);
    push_cmd(1'b1, 2'b00, 5'd2, 5'd1, 16'h0010, 1'b0, 16'h0);
    push_cmd(1'b1, 2'b11, 5'd2, 5'd1, 16'h0000, 1'b0, 16'hCAFE);
    wait_frames(4, 400, "c45_frames");
    check("c45_gap", 64'((gap_t > 40) && (gap_t <= 80)), 64'd1);
    wait_idle(20, "c45_idle");
    cfg_read(5'h02, d);
    check("c45_rxdata", 64'(d), 64'(rxq.pop_front()));

    // Overflow: slow blocker frame keeps the engine busy while the FIFO fills
    base = frames_seen;
    cfg_write(5'h03, 32'd255);
    push_cmd(1'b0, 2'b01, 5'd5, 5'd6, 16'hA5A5, 1'b0, 16'h0);
    @(posedge clk); #1;
    cfg_write(5'h03, 32'd1);
    for (int unsigned i = 0; i < 5; i++) begin
      if (i < 4) push_cmd(1'b0, 2'b01, 5'(i), 5'(i + 8), 16'(16'h1000 + i), 1'b0, 16'h0);
      else       cfg_write(5'h00, {3'b0, 1'b0, 2'b01, 5'd9, 5'd9, 16'hDEAD});
    end
    cfg_read(5'h01, d);
    check("ovf_status", 64'(d), 64'h40D);
    cfg_write(5'h04, 32'h9);
    cfg_read(5'h01, d);
    check("ovf_cleared", 64'(d), 64'h405);
    wait_frames(base + 5, 20000, "ovf_frames");
    wait_idle(40, "ovf_idle");
    check("ovf_frame_count", 64'(frames_seen - base), 64'd5);
    check("ovf_queue_drained", 64'(fq.size()), 64'd0);

    // Async reset in the middle of a read's DATA phase
    cfg_write(5'h04, 32'h3);
    push_cmd(1'b0, 2'b10, 5'd7, 5'd9, 16'h0, 1'b0, 16'h5555);
    push_cmd(1'b0, 2'b01, 5'd7, 5'd9, 16'h1111, 1'b0, 16'h0);
    begin
      int unsigned k = 0;
      while (cur_len < 20 && k < 300) begin @(posedge clk); k++; end
      check("reset_reached_data", 64'(cur_len >= 20), 64'd1);
    end
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_mdc", 64'(mdc_o), 64'd0);
    check("mid_rst_mdio", 64'(mdio_o), 64'd1);
    check("mid_rst_oe", 64'(mdio_oe_o), 64'd0);
    check("mid_rst_irq", 64'(irq_o), 64'd0);
    rxq.delete();
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    cfg_read(5'h01, d);
    check("post_rst_status", 64'(d), 64'h2);
    cfg_read(5'h02, d);
    check("post_rst_rxdata", 64'(d), 64'h0);
    cfg_read(5'h03, d);
    check("post_rst_clkdiv", 64'(d), 64'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
